// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath/memory side.
// The master modport drives the control word; the slave modport supplies the status inputs.
interface multicycle_controller_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, illegal, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, illegal, state_dbg
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main RV32I multicycle control FSM; Moore control word plus Mealy pc_write, stalls on mem_ready.
// Optional macro MC_JAL_EN adds the JAL state; without it opcode 1101111 is flagged illegal.
module multicycle_controller (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_controller_if.master  ctrl
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
`ifdef MC_JAL_EN
    localparam logic [3:0] S_JAL      = 4'd10;
`endif

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
`ifdef MC_JAL_EN
    localparam logic [6:0] OP_JAL  = 7'b1101111;
`endif

    logic [3:0] state_q, state_d;
    logic       pc_update, branch;
    logic       adr_src, ir_write, mem_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ctrl.mem_ready;
                pc_update  = ctrl.mem_ready;
                if (ctrl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU computes oldPC + imm here so BEQ/JAL find the target in ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MC_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (ctrl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ctrl.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ctrl.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks the whole control word so no strobe is seen while rst is high
    assign ctrl.pc_write   = ~rst & (pc_update | (branch & ctrl.zero));
    assign ctrl.adr_src    = ~rst & adr_src;
    assign ctrl.ir_write   = ~rst & ir_write;
    assign ctrl.mem_write  = ~rst & mem_write;
    assign ctrl.reg_write  = ~rst & reg_write;
    assign ctrl.illegal    = ~rst & illegal;
    assign ctrl.result_src = rst ? 2'b00 : result_src;
    assign ctrl.alu_src_a  = rst ? 2'b00 : alu_src_a;
    assign ctrl.alu_src_b  = rst ? 2'b00 : alu_src_b;
    assign ctrl.alu_op     = rst ? 2'b00 : alu_op;
    assign ctrl.state_dbg  = state_q;
endmodule
